// File: rtl/fmap_iii_ctrl.sv
// fmap_iii_ctrl: fill/drain sequencer for the 64-bank layer-III feature-map buffer; FMAP_III_CTRL_RELU_EN clamps negative outputs to 0.
// Latency: bank write in the input-handshake cycle; first out_valid one cycle after DRAIN entry, then 1 vector/cycle.
// Backpressure: in_ready low for the whole drain; out_ready low holds rd_addr so the banks re-present the same word.
module fmap_iii_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [64*DATA_WIDTH-1:0]     in_data,
  output logic [64*ADDR_WIDTH-1:0]     fmap_wr_addr,
  output logic [63:0]                  fmap_wr_en,
  output logic [64*DATA_WIDTH-1:0]     fmap_wr_data,
  output logic [64*ADDR_WIDTH-1:0]     fmap_rd_addr,
  input  logic [64*DATA_WIDTH-1:0]     fmap_rd_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [64*DATA_WIDTH-1:0]     out_data,
  output logic                         frame_done
);

  localparam int LANES = 64;
  localparam int PW    = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] WR_LAST = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [PW-1:0]         RD_END  = PW'(DEPTH);

  typedef enum logic {ST_FILL, ST_DRAIN} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic                  wr_fire;
  logic                  rd_issue;
  logic                  out_fire;
  logic                  last_fire;
  logic [ADDR_WIDTH-1:0] rd_addr;

  assign wr_fire   = (state == ST_FILL) && in_valid && in_ready && !rst;
  assign rd_issue  = (state == ST_DRAIN) && (rd_ptr < RD_END) && (!out_valid || out_ready);
  assign out_fire  = out_valid && out_ready;
  // rd_ptr has already advanced past the presented word, so RD_END marks word DEPTH-1 on the output
  assign last_fire = (state == ST_DRAIN) && out_fire && (rd_ptr == RD_END) && !rst;

  // While stalled the last issued address is replayed, keeping out_data stable
  assign rd_addr = rd_issue ? rd_ptr[ADDR_WIDTH-1:0] : rd_addr_q;

  assign fmap_wr_addr = {LANES{wr_ptr}};
  assign fmap_wr_en   = {LANES{wr_fire}};
  assign fmap_wr_data = in_data;
  assign fmap_rd_addr = {LANES{rd_addr}};
  assign frame_done   = last_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_FILL;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rd_addr_q <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_FILL: begin
          if (wr_fire) begin
            if (wr_ptr == WR_LAST) begin
              wr_ptr   <= '0;
              state    <= ST_DRAIN;
              in_ready <= 1'b0;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (rd_issue) begin
            rd_ptr    <= rd_ptr + 1'b1;
            rd_addr_q <= rd_ptr[ADDR_WIDTH-1:0];
            out_valid <= 1'b1;
          end else if (out_fire) begin
            out_valid <= 1'b0;
          end
          if (last_fire) begin
            rd_ptr    <= '0;
            rd_addr_q <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_FILL;
          end
        end
        default: state <= ST_FILL;
      endcase
    end
  end

`ifdef FMAP_III_CTRL_RELU_EN
  always_comb begin
    out_data = fmap_rd_data;
    for (int q = 0; q < LANES; q++) begin
      if (fmap_rd_data[q*DATA_WIDTH + DATA_WIDTH - 1]) begin
        out_data[q*DATA_WIDTH +: DATA_WIDTH] = '0;
      end
    end
  end
`else
  assign out_data = fmap_rd_data;
`endif

endmodule

// File: tb/tb_fmap_iii_ctrl.sv
// Bench for fmap_iii_ctrl: behavioural bank model plus a queue-based frame scoreboard.
module tb_fmap_iii_ctrl;
  localparam int AW = 4, DW = 16, DEPTH = 16, L = 64;
  localparam int AW1 = 1;
`ifdef FMAP_III_CTRL_RELU_EN
  localparam logic [DW-1:0] NEG_EXP = 16'h0000;
`else
  localparam logic [DW-1:0] NEG_EXP = 16'h8001;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, frame_done;
  logic [L*DW-1:0] in_data = '0, fmap_wr_data, fmap_rd_data, out_data;
  logic [L*AW-1:0] fmap_wr_addr, fmap_rd_addr;
  logic [L-1:0]    fmap_wr_en;
  logic [DW-1:0]   bank [L][1<<AW];

  logic d1_in_valid = 1'b0, d1_in_ready, d1_out_valid, d1_out_ready = 1'b0, d1_frame_done;
  logic [L*DW-1:0] d1_in_data = '0, d1_wr_data, d1_rd_data, d1_out_data;
  logic [L*AW1-1:0] d1_wr_addr, d1_rd_addr;
  logic [L-1:0]    d1_wr_en;
  logic [DW-1:0]   bank1 [L][1<<AW1];

  int errors = 0;
  int checks = 0;
  logic [L*DW-1:0] exp_q[$];

  fmap_iii_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .fmap_wr_addr(fmap_wr_addr), .fmap_wr_en(fmap_wr_en), .fmap_wr_data(fmap_wr_data),
    .fmap_rd_addr(fmap_rd_addr), .fmap_rd_data(fmap_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .frame_done(frame_done)
  );

  fmap_iii_ctrl #(.ADDR_WIDTH(AW1), .DATA_WIDTH(DW), .DEPTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(d1_in_valid), .in_ready(d1_in_ready), .in_data(d1_in_data),
    .fmap_wr_addr(d1_wr_addr), .fmap_wr_en(d1_wr_en), .fmap_wr_data(d1_wr_data),
    .fmap_rd_addr(d1_rd_addr), .fmap_rd_data(d1_rd_data),
    .out_valid(d1_out_valid), .out_ready(d1_out_ready), .out_data(d1_out_data),
    .frame_done(d1_frame_done)
  );

  always #5 clk = ~clk;

  // Banks: synchronous write, registered 1-cycle read, independent address per lane
  always @(posedge clk) begin
    for (int q = 0; q < L; q++) begin
      if (fmap_wr_en[q]) bank[q][fmap_wr_addr[q*AW +: AW]] <= fmap_wr_data[q*DW +: DW];
      fmap_rd_data[q*DW +: DW] <= bank[q][fmap_rd_addr[q*AW +: AW]];
      if (d1_wr_en[q]) bank1[q][d1_wr_addr[q*AW1 +: AW1]] <= d1_wr_data[q*DW +: DW];
      d1_rd_data[q*DW +: DW] <= bank1[q][d1_rd_addr[q*AW1 +: AW1]];
    end
  end

  function automatic logic [L*DW-1:0] rand_vec();
    logic [L*DW-1:0] v;
    for (int q = 0; q < L; q++) v[q*DW +: DW] = DW'($urandom);
    return v;
  endfunction

  // Expected output: negative lanes become zero when the ReLU build option is on
  function automatic logic [L*DW-1:0] model_out(input logic [L*DW-1:0] v);
    logic [L*DW-1:0] r;
    logic signed [DW-1:0] w;
    r = v;
`ifdef FMAP_III_CTRL_RELU_EN
    for (int q = 0; q < L; q++) begin
      w = v[q*DW +: DW];
      if (w < 0) r[q*DW +: DW] = '0;
    end
`else
    w = '0;
`endif
    return r;
  endfunction

  function automatic int first_diff(input logic [L*DW-1:0] a, input logic [L*DW-1:0] b);
    for (int q = 0; q < L; q++) if (a[q*DW +: DW] !== b[q*DW +: DW]) return q;
    return 0;
  endfunction

  // Stimulus only: n accepted input vectors on consecutive cycles, recorded in exp_q
  task automatic fill_frame(input int n);
    logic [L*DW-1:0] v;
    for (int i = 0; i < n; i++) begin
      v = rand_vec();
      in_valid = 1'b1;
      in_data  = v;
      exp_q.push_back(v);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
    checks++; if (fmap_wr_en !== '0) begin errors++; $display("FAIL reset_wr_en got %h want 0", fmap_wr_en); end
    checks++; if (fmap_wr_addr !== '0) begin errors++; $display("FAIL reset_wr_addr got %h want 0", fmap_wr_addr); end
    checks++; if (fmap_rd_addr !== '0) begin errors++; $display("FAIL reset_rd_addr got %h want 0", fmap_rd_addr); end
    checks++; if (d1_in_ready !== 1'b1) begin errors++; $display("FAIL reset_d1_in_ready got %b want 1", d1_in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_fill_drain();
    logic [L*DW-1:0] v, e;
    logic [AW-1:0] a;
    logic fd;
    int l;
    exp_q.delete();
    out_ready = 1'b1;
    for (int n = 0; n < DEPTH; n++) begin
      for (int q = 0; q < L; q++) v[q*DW +: DW] = DW'(16*n + q);
      a = AW'(n);
      in_valid = 1'b1; in_data = v; exp_q.push_back(v);
      @(negedge clk);
      checks++; if (fmap_wr_en !== {L{1'b1}}) begin errors++; $display("FAIL fill_wr_en n=%0d got %h want all ones", n, fmap_wr_en); end
      checks++; if (fmap_wr_addr !== {L{a}}) begin errors++; $display("FAIL fill_wr_addr n=%0d got %h want %h", n, fmap_wr_addr, {L{a}}); end
      checks++; if (fmap_wr_data !== v) begin errors++; l = first_diff(fmap_wr_data, v); $display("FAIL fill_wr_data n=%0d lane %0d got %h want %h", n, l, fmap_wr_data[l*DW +: DW], v[l*DW +: DW]); end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL entry_in_ready got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL entry_out_valid got %b want 0", out_valid); end
    checks++; if (fmap_rd_addr !== '0) begin errors++; $display("FAIL entry_rd_addr got %h want 0", fmap_rd_addr); end
    @(posedge clk); #1;
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge clk);
      e  = model_out(exp_q[k]);
      fd = (k == DEPTH - 1);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL drain_out_valid k=%0d got %b want 1", k, out_valid); end
      checks++; if (out_data !== e) begin errors++; l = first_diff(out_data, e); $display("FAIL drain_out_data k=%0d lane %0d got %h want %h", k, l, out_data[l*DW +: DW], e[l*DW +: DW]); end
      checks++; if (frame_done !== fd) begin errors++; $display("FAIL drain_frame_done k=%0d got %b want %b", k, frame_done, fd); end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL done_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL done_out_valid got %b want 0", out_valid); end
    @(posedge clk); #1;
    exp_q.delete();
  endtask

  task automatic test_stall();
    logic [L*DW-1:0] e;
    logic [AW-1:0] a;
    logic fd;
    int got, cyc, l;
    exp_q.delete();
    out_ready = 1'b0;
    fill_frame(DEPTH);
    got = 0; cyc = 0;
    while (got < DEPTH && cyc < 300) begin
      out_ready = (cyc < 36) ? ((cyc % 3) == 0) : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (out_valid === 1'b1) begin
        e = model_out(exp_q[0]);
        checks++; if (out_data !== e) begin errors++; l = first_diff(out_data, e); $display("FAIL stall_out_data word=%0d lane %0d got %h want %h", got, l, out_data[l*DW +: DW], e[l*DW +: DW]); end
        if (out_ready === 1'b0) begin
          a = AW'(got);
          checks++; if (fmap_rd_addr !== {L{a}}) begin errors++; $display("FAIL stall_rd_addr word=%0d got %h want %h", got, fmap_rd_addr, {L{a}}); end
        end else begin
          fd = (got == DEPTH - 1);
          checks++; if (frame_done !== fd) begin errors++; $display("FAIL stall_frame_done word=%0d got %b want %b", got, frame_done, fd); end
          void'(exp_q.pop_front());
          got++;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    checks++; if (got != DEPTH) begin errors++; $display("FAIL stall_word_count got %0d want %0d", got, DEPTH); end
    out_ready = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_bubbles();
    logic [L*DW-1:0] v, e;
    logic [AW-1:0] a;
    int acc, cyc, got, l;
    exp_q.delete();
    acc = 0; cyc = 0;
    while (acc < DEPTH && cyc < 200) begin
      in_valid = (cyc % 2 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      v = rand_vec(); in_data = v;
      @(negedge clk);
      if (in_valid) begin
        a = AW'(acc);
        checks++; if (fmap_wr_en !== {L{1'b1}} || fmap_wr_addr !== {L{a}}) begin errors++; $display("FAIL bubble_write acc=%0d got en=%h addr=%h want addr=%h", acc, fmap_wr_en, fmap_wr_addr, {L{a}}); end
        exp_q.push_back(v);
        acc++;
      end else begin
        checks++; if (fmap_wr_en !== '0) begin errors++; $display("FAIL bubble_wr_en cyc=%0d got %h want 0", cyc, fmap_wr_en); end
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b1; out_ready = 1'b1;
    got = 0; cyc = 0;
    while (got < DEPTH && cyc < 100) begin
      in_data = rand_vec();
      @(negedge clk);
      checks++; if (fmap_wr_en !== '0 || in_ready !== 1'b0) begin errors++; $display("FAIL drain_ignores_input cyc=%0d got en=%h in_ready=%b want 0", cyc, fmap_wr_en, in_ready); end
      if (out_valid === 1'b1) begin
        e = model_out(exp_q.pop_front());
        checks++; if (out_data !== e) begin errors++; l = first_diff(out_data, e); $display("FAIL bubble_out_data word=%0d lane %0d got %h want %h", got, l, out_data[l*DW +: DW], e[l*DW +: DW]); end
        got++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    checks++; if (got != DEPTH) begin errors++; $display("FAIL bubble_word_count got %0d want %0d", got, DEPTH); end
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bubble_done_in_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    logic [L*DW-1:0] e;
    logic [AW-1:0] a;
    logic fd;
    int got, cyc, l;
    exp_q.delete();
    fill_frame(7);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL midrst_state got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int n = 0; n < DEPTH; n++) begin
      e = rand_vec();
      in_valid = 1'b1; in_data = e; exp_q.push_back(e);
      a = AW'(n);
      @(negedge clk);
      checks++; if (fmap_wr_addr !== {L{a}}) begin errors++; $display("FAIL midrst_wr_addr n=%0d got %h want %h", n, fmap_wr_addr, {L{a}}); end
      checks++; if (out_valid !== 1'b0 || frame_done !== 1'b0) begin errors++; $display("FAIL midrst_fill_quiet n=%0d got out_valid=%b frame_done=%b want 0/0", n, out_valid, frame_done); end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    got = 0; cyc = 0;
    while (got < DEPTH && cyc < 100) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        e  = model_out(exp_q.pop_front());
        fd = (got == DEPTH - 1);
        checks++; if (out_data !== e) begin errors++; l = first_diff(out_data, e); $display("FAIL midrst_out_data word=%0d lane %0d got %h want %h", got, l, out_data[l*DW +: DW], e[l*DW +: DW]); end
        checks++; if (frame_done !== fd) begin errors++; $display("FAIL midrst_frame_done word=%0d got %b want %b", got, frame_done, fd); end
        got++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    checks++; if (got != DEPTH) begin errors++; $display("FAIL midrst_word_count got %0d want %0d", got, DEPTH); end
    exp_q.delete();
  endtask

  task automatic test_relu();
    logic [L*DW-1:0] v, e;
    int got, cyc, l;
    exp_q.delete();
    v = rand_vec();
    v[DW-1:0]    = 16'h8001;
    v[2*DW-1:DW] = 16'h7FFF;
    in_valid = 1'b1; in_data = v; exp_q.push_back(v);
    @(posedge clk); #1;
    fill_frame(DEPTH - 1);
    out_ready = 1'b1;
    got = 0; cyc = 0;
    while (got < DEPTH && cyc < 100) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        e = model_out(exp_q.pop_front());
        if (got == 0) begin
          checks++; if (out_data[DW-1:0] !== NEG_EXP) begin errors++; $display("FAIL relu_neg_lane got %h want %h", out_data[DW-1:0], NEG_EXP); end
          checks++; if (out_data[2*DW-1:DW] !== 16'h7FFF) begin errors++; $display("FAIL relu_pos_lane got %h want 7fff", out_data[2*DW-1:DW]); end
        end
        checks++; if (out_data !== e) begin errors++; l = first_diff(out_data, e); $display("FAIL relu_out_data word=%0d lane %0d got %h want %h", got, l, out_data[l*DW +: DW], e[l*DW +: DW]); end
        got++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    checks++; if (got != DEPTH) begin errors++; $display("FAIL relu_word_count got %0d want %0d", got, DEPTH); end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [L*DW-1:0] v, e;
    int t, got, l;
    bit seen;
    out_ready = 1'b1;
    for (int f = 0; f < 2; f++) begin
      exp_q.delete();
      t = 0;
      for (int n = 0; n < DEPTH; n++) begin
        v = rand_vec();
        in_valid = 1'b1; in_data = v; exp_q.push_back(v);
        @(negedge clk);
        t++;
        if (n == 0) begin
          checks++; if (fmap_wr_en !== {L{1'b1}} || fmap_wr_addr !== '0) begin errors++; $display("FAIL b2b_first_write frame=%0d got en=%h addr=%h want all ones/0", f, fmap_wr_en, fmap_wr_addr); end
        end
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
      got = 0; seen = 0;
      while (got < DEPTH && t < 100) begin
        @(negedge clk);
        t++;
        if (out_valid === 1'b1) begin
          e = model_out(exp_q.pop_front());
          checks++; if (out_data !== e) begin errors++; l = first_diff(out_data, e); $display("FAIL b2b_out_data frame=%0d word=%0d lane %0d got %h want %h", f, got, l, out_data[l*DW +: DW], e[l*DW +: DW]); end
          if (frame_done === 1'b1) begin
            seen = 1;
            checks++; if (t != 2*DEPTH + 1) begin errors++; $display("FAIL b2b_turnaround frame=%0d got %0d cycles want %0d", f, t, 2*DEPTH + 1); end
          end
          got++;
        end
        @(posedge clk); #1;
      end
      checks++; if (!seen || got != DEPTH) begin errors++; $display("FAIL b2b_frame_end frame=%0d got words=%0d done_seen=%0d want %0d/1", f, got, seen, DEPTH); end
    end
    exp_q.delete();
  endtask

  task automatic test_depth1();
    logic [L*DW-1:0] v, e;
    int l;
    v = rand_vec();
    d1_in_valid = 1'b1; d1_in_data = v; d1_out_ready = 1'b1;
    @(negedge clk);
    checks++; if (d1_wr_en !== {L{1'b1}} || d1_wr_addr !== '0) begin errors++; $display("FAIL d1_write got en=%h addr=%h want all ones/0", d1_wr_en, d1_wr_addr); end
    @(posedge clk); #1;
    d1_in_data = rand_vec();
    @(negedge clk);
    checks++; if (d1_in_ready !== 1'b0 || d1_out_valid !== 1'b0 || d1_wr_en !== '0) begin errors++; $display("FAIL d1_entry got in_ready=%b out_valid=%b en=%h want 0/0/0", d1_in_ready, d1_out_valid, d1_wr_en); end
    @(posedge clk); #1;
    @(negedge clk);
    e = model_out(v);
    checks++; if (d1_out_valid !== 1'b1 || d1_frame_done !== 1'b1) begin errors++; $display("FAIL d1_output got out_valid=%b frame_done=%b want 1/1", d1_out_valid, d1_frame_done); end
    checks++; if (d1_out_data !== e) begin errors++; l = first_diff(d1_out_data, e); $display("FAIL d1_out_data lane %0d got %h want %h", l, d1_out_data[l*DW +: DW], e[l*DW +: DW]); end
    @(posedge clk); #1;
    d1_in_valid = 1'b0;
    @(negedge clk);
    checks++; if (d1_in_ready !== 1'b1 || d1_out_valid !== 1'b0) begin errors++; $display("FAIL d1_done got in_ready=%b out_valid=%b want 1/0", d1_in_ready, d1_out_valid); end
    @(posedge clk); #1;
    d1_out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill_drain();
    test_stall();
    test_bubbles();
    test_reset_mid();
    test_relu();
    test_back_to_back();
    test_depth1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
